// File: rtl/vortex_launch_ctrl.sv
// vortex_launch_ctrl: control/status register block that sequences a Vortex
// kernel launch. Holds the core in reset, releases it on a software START,
// tracks busy until completion, then raises a sticky done flag and an irq.
// Optional feature macro: VORTEX_LAUNCH_WATCHDOG_EN (run-length watchdog
// driven by the TIMEOUT register; without it TIMEOUT is plain storage).
module vortex_launch_ctrl #(
  parameter int          ADDR_WIDTH             = 32,
  parameter int          DATA_WIDTH             = 32,
  parameter logic [31:0] PC_RESET_VAL_RESET_VAL = 32'hF000_0000,
  parameter int          RESET_HOLD_CYCLES      = 8,
  parameter int          BUSY_WAIT_CYCLES       = 16
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    wen,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error,
  output logic                    request_stall,
  input  logic                    Vortex_busy,
  output logic                    Vortex_reset,
  output logic [31:0]             Vortex_PC_reset_val,
  output logic                    irq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    ARM  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_START   = 3'd1;
  localparam logic [2:0] OFF_PC      = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd3;
  localparam logic [2:0] OFF_TIMEOUT = 3'd4;

  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST = 32'(BUSY_WAIT_CYCLES - 1);

  state_t                state;
  logic [31:0]           counter;
  logic                  done_q;
  logic                  timeout_q;
  logic                  irq_en_q;
  logic                  reset_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] timeout_limit_q;

  logic [2:0]            reg_idx;
  logic                  core_busy;
  logic                  bus_error;
  logic                  wr_ok;
  logic                  start_req;
  logic                  clear_req;
  logic                  wd_expire;
  logic [DATA_WIDTH-1:0] read_word;
  logic                  unused_addr;

  assign reg_idx     = addr[4:2];
  assign unused_addr = ^{addr[ADDR_WIDTH-1:5], addr[1:0]};
  assign core_busy   = (state != IDLE) && (state != DONE);

  // Merge new write data into an existing register honouring byte enables.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_val,
    input logic [DATA_WIDTH-1:0]   new_val,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Flag unmapped accesses, STATUS writes and PC writes while a launch is active.
  always_comb begin
    bus_error = 1'b0;
    if ((wen || ren) && (reg_idx > OFF_TIMEOUT)) bus_error = 1'b1;
    if (wen && (reg_idx == OFF_STATUS)) bus_error = 1'b1;
    if (wen && (reg_idx == OFF_PC) && core_busy) bus_error = 1'b1;
  end

  assign wr_ok     = wen && !bus_error;
  assign start_req = wr_ok && (reg_idx == OFF_START) && strobe[0] && wdata[0];
  assign clear_req = wr_ok && (reg_idx == OFF_CTRL) && strobe[0] && wdata[1];

  // Combinational read mux; idle bus returns zero.
  always_comb begin
    read_word = '0;
    if (ren) begin
      case (reg_idx)
        OFF_STATUS:  read_word = DATA_WIDTH'({timeout_q, done_q, core_busy});
        OFF_PC:      read_word = pc_q;
        OFF_CTRL:    read_word = DATA_WIDTH'(irq_en_q);
        OFF_TIMEOUT: read_word = timeout_limit_q;
        default:     read_word = '0;
      endcase
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pc_q            <= DATA_WIDTH'(PC_RESET_VAL_RESET_VAL);
      irq_en_q        <= 1'b0;
      timeout_limit_q <= '0;
    end else if (wr_ok) begin
      case (reg_idx)
        OFF_PC:      pc_q <= merge_bytes(pc_q, wdata, strobe);
        OFF_CTRL:    if (strobe[0]) irq_en_q <= wdata[0];
        OFF_TIMEOUT: timeout_limit_q <= merge_bytes(timeout_limit_q, wdata, strobe);
        default:     ;
      endcase
    end
  end

`ifdef VORTEX_LAUNCH_WATCHDOG_EN
  logic [DATA_WIDTH-1:0] run_cnt;

  assign wd_expire = ((state == ARM) || (state == RUN)) &&
                     (timeout_limit_q != '0) &&
                     (run_cnt == timeout_limit_q - 1'b1);

  // Saturating run-length counter, restarted as the core leaves reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      run_cnt <= '0;
    end else if ((state == HOLD) && (counter == HOLD_LAST)) begin
      run_cnt <= '0;
    end else if (((state == ARM) || (state == RUN)) && (run_cnt != '1)) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // Launch sequencer: flag clears land first so a completion or launch in the same cycle overrides them.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      counter   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      reset_q   <= 1'b1;
    end else begin
      if (clear_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          reset_q <= 1'b1;
          if (start_req) begin
            state   <= HOLD;
            counter <= '0;
            done_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (counter == HOLD_LAST) begin
            state   <= ARM;
            counter <= '0;
            reset_q <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ARM: begin
          if (wd_expire) begin
            state     <= DONE;
            reset_q   <= 1'b1;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (Vortex_busy) begin
            state <= RUN;
          end else if (counter == WAIT_LAST) begin
            state   <= DONE;
            reset_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RUN: begin
          if (wd_expire) begin
            state     <= DONE;
            reset_q   <= 1'b1;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (!Vortex_busy) begin
            state   <= DONE;
            reset_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          reset_q <= 1'b1;
          if (start_req) begin
            state   <= HOLD;
            counter <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign rdata               = read_word;
  assign error               = bus_error;
  assign request_stall       = 1'b0;
  assign Vortex_reset        = reset_q;
  assign Vortex_PC_reset_val = pc_q[31:0];
  assign irq                 = done_q & irq_en_q;

endmodule

// File: tb/tb_vortex_launch_ctrl.sv
// tb_vortex_launch_ctrl: directed self-checking bench for vortex_launch_ctrl.
// Covers register access, launch timing, empty kernels, bus errors while
// running, the watchdog (when VORTEX_LAUNCH_WATCHDOG_EN is defined) and
// asynchronous reset in the middle of a run.
module tb_vortex_launch_ctrl;

  logic        clk = 1'b0;
  logic        nRST;
  logic        wen;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        error;
  logic        request_stall;
  logic        Vortex_busy;
  logic        Vortex_reset;
  logic [31:0] Vortex_PC_reset_val;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int hi_cnt;
  int lo_cnt;

  localparam logic [31:0] A_STATUS  = 32'h00;
  localparam logic [31:0] A_START   = 32'h04;
  localparam logic [31:0] A_PC      = 32'h08;
  localparam logic [31:0] A_CTRL    = 32'h0C;
  localparam logic [31:0] A_TIMEOUT = 32'h10;
  localparam logic [31:0] A_UNMAP5  = 32'h14;
  localparam logic [31:0] A_UNMAP6  = 32'h18;
  localparam logic [31:0] A_UNMAP7  = 32'h1C;

  vortex_launch_ctrl dut (
    .clk                 (clk),
    .nRST                (nRST),
    .wen                 (wen),
    .ren                 (ren),
    .addr                (addr),
    .wdata               (wdata),
    .strobe              (strobe),
    .rdata               (rdata),
    .error               (error),
    .request_stall       (request_stall),
    .Vortex_busy         (Vortex_busy),
    .Vortex_reset        (Vortex_reset),
    .Vortex_PC_reset_val (Vortex_PC_reset_val),
    .irq                 (irq)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic bus_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic exp_err);
    @(negedge clk);
    wen = 1'b1; addr = a; wdata = d; strobe = s;
    #1 check_output({tag, " error"}, 32'(error), 32'(exp_err));
    @(posedge clk);
    #1 wen = 1'b0; addr = '0; wdata = '0; strobe = '0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                          input logic exp_err);
    @(negedge clk);
    ren = 1'b1; addr = a;
    #1 check_output({tag, " rdata"}, rdata, exp_data);
    check_output({tag, " error"}, 32'(error), 32'(exp_err));
    @(posedge clk);
    #1 ren = 1'b0; addr = '0;
  endtask

  // Count negedges with the core held in reset after a START, stopping at the first released sample.
  task automatic wait_release(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!Vortex_reset) break;
      n++;
    end
  endtask

  // Starting at a negedge with the core released, count released negedges while driving busy on a schedule.
  task automatic apply_stimulus(input int busy_on, input int busy_off, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (Vortex_reset) break;
      n++;
      if (i == busy_on)  Vortex_busy = 1'b1;
      if (i == busy_off) Vortex_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_reset_high();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Vortex_reset) break;
    end
  endtask

  initial begin
    nRST = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; strobe = '0;
    Vortex_busy = 1'b0;
    #12;
    check_output("rst vortex_reset", 32'(Vortex_reset), 32'd1);
    check_output("rst irq", 32'(irq), 32'd0);
    @(negedge clk) nRST = 1'b1;

    // Reset values
    bus_read("status reset", A_STATUS, 32'h0, 1'b0);
    bus_read("pc reset", A_PC, 32'hF000_0000, 1'b0);
    bus_read("ctrl reset", A_CTRL, 32'h0, 1'b0);
    bus_read("timeout reset", A_TIMEOUT, 32'h0, 1'b0);
    bus_read("start reads 0", A_START, 32'h0, 1'b0);
    check_output("idle request_stall", 32'(request_stall), 32'd0);
    check_output("idle vortex_reset", 32'(Vortex_reset), 32'd1);

    // Byte-strobed PC write, then full PC write
    bus_write("pc partial", A_PC, 32'h1234_5678, 4'b0011, 1'b0);
    bus_read("pc partial", A_PC, 32'hF000_5678, 1'b0);
    bus_write("pc full", A_PC, 32'h8000_0000, 4'b1111, 1'b0);
    check_output("pc output", Vortex_PC_reset_val, 32'h8000_0000);

    // Error cases in idle
    bus_write("write status", A_STATUS, 32'hFFFF_FFFF, 4'hF, 1'b1);
    bus_read("status after bad write", A_STATUS, 32'h0, 1'b0);
    bus_read("read unmapped 5", A_UNMAP5, 32'h0, 1'b1);
    bus_write("write unmapped 7", A_UNMAP7, 32'h1, 4'hF, 1'b1);

    // Launch with busy rising 3 cycles after release and held 100 cycles
    bus_write("start 1", A_START, 32'h1, 4'hF, 1'b0);
    wait_release(hi_cnt);
    check_output("hold length", 32'(hi_cnt), 32'd8);
    apply_stimulus(3, 103, lo_cnt);
    check_output("release span", 32'(lo_cnt), 32'd104);
    bus_read("status done", A_STATUS, 32'h2, 1'b0);
    check_output("irq disabled", 32'(irq), 32'd0);
    bus_write("irq enable", A_CTRL, 32'h1, 4'hF, 1'b0);
    check_output("irq enabled", 32'(irq), 32'd1);
    bus_read("ctrl irq_en", A_CTRL, 32'h1, 1'b0);

    // Clear flags, then empty kernel (busy never asserts)
    bus_write("ctrl clear", A_CTRL, 32'h2, 4'hF, 1'b0);
    bus_read("status cleared", A_STATUS, 32'h0, 1'b0);
    check_output("irq after clear", 32'(irq), 32'd0);
    bus_write("start empty", A_START, 32'h1, 4'hF, 1'b0);
    wait_release(hi_cnt);
    check_output("hold length empty", 32'(hi_cnt), 32'd8);
    apply_stimulus(-1, -1, lo_cnt);
    check_output("empty kernel span", 32'(lo_cnt), 32'd16);
    bus_read("status empty done", A_STATUS, 32'h2, 1'b0);

    // Bus behaviour while running
    Vortex_busy = 1'b1;
    bus_write("start run", A_START, 32'h1, 4'hF, 1'b0);
    wait_release(hi_cnt);
    bus_write("pc write running", A_PC, 32'h1111_1111, 4'hF, 1'b1);
    bus_read("pc unchanged", A_PC, 32'h8000_0000, 1'b0);
    bus_read("read unmapped 6", A_UNMAP6, 32'h0, 1'b1);
    bus_write("second start", A_START, 32'h1, 4'hF, 1'b0);
    bus_read("status running", A_STATUS, 32'h1, 1'b0);
    check_output("running vortex_reset", 32'(Vortex_reset), 32'd0);
    @(negedge clk) Vortex_busy = 1'b0;
    wait_reset_high();
    check_output("run end vortex_reset", 32'(Vortex_reset), 32'd1);
    bus_read("status run done", A_STATUS, 32'h2, 1'b0);

    // TIMEOUT register and watchdog
    bus_write("timeout write", A_TIMEOUT, 32'd50, 4'hF, 1'b0);
    bus_read("timeout readback", A_TIMEOUT, 32'd50, 1'b0);
    Vortex_busy = 1'b1;
    bus_write("start watchdog", A_START, 32'h1, 4'hF, 1'b0);
    wait_release(hi_cnt);
`ifdef VORTEX_LAUNCH_WATCHDOG_EN
    apply_stimulus(-1, -1, lo_cnt);
    check_output("watchdog span", 32'(lo_cnt), 32'd50);
    bus_read("status timeout", A_STATUS, 32'h6, 1'b0);
    check_output("watchdog vortex_reset", 32'(Vortex_reset), 32'd1);
    bus_write("ctrl clear timeout", A_CTRL, 32'h2, 4'hF, 1'b0);
    bus_read("status after clear", A_STATUS, 32'h0, 1'b0);
    Vortex_busy = 1'b0;
`else
    repeat (60) @(negedge clk);
    check_output("no watchdog vortex_reset", 32'(Vortex_reset), 32'd0);
    bus_read("status no timeout", A_STATUS, 32'h1, 1'b0);
    @(negedge clk) Vortex_busy = 1'b0;
    wait_reset_high();
    bus_read("status no timeout done", A_STATUS, 32'h2, 1'b0);
`endif

    // Asynchronous reset in the middle of a run
    bus_write("irq enable 2", A_CTRL, 32'h1, 4'hF, 1'b0);
    Vortex_busy = 1'b1;
    bus_write("start for reset", A_START, 32'h1, 4'hF, 1'b0);
    wait_release(hi_cnt);
    repeat (3) @(negedge clk);
    check_output("pre-reset vortex_reset", 32'(Vortex_reset), 32'd0);
    #2 nRST = 1'b0;
    #1 check_output("async vortex_reset", 32'(Vortex_reset), 32'd1);
    check_output("async irq", 32'(irq), 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    Vortex_busy = 1'b0;
    bus_read("status post reset", A_STATUS, 32'h0, 1'b0);
    bus_read("pc post reset", A_PC, 32'hF000_0000, 1'b0);
    bus_read("ctrl post reset", A_CTRL, 32'h0, 1'b0);
    bus_read("timeout post reset", A_TIMEOUT, 32'h0, 1'b0);
    check_output("post reset vortex_reset", 32'(Vortex_reset), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
